// File: rtl/sqrt_arb_pkg.sv
// Shared types for the square-root arbiter: FSM states, default widths and
// the round-robin grant search.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam int WIDTH_DEF = 23;
  localparam int OUT_W_DEF = 12;
  localparam int RR_MAX    = 8;

  typedef struct packed {
    logic              vld;
    logic [2:0]        idx;
    logic [RR_MAX-1:0] gnt;
  } rr_grant_t;

  // First set request searching upward from ptr+1, wrapping modulo n.
  function automatic rr_grant_t rr_next_grant(input logic [RR_MAX-1:0] req,
                                              input logic [2:0]        ptr,
                                              input int                n);
    rr_grant_t g;
    int        pos;
    g = '0;
    for (int i = 1; i <= RR_MAX; i++) begin
      pos = (int'(ptr) + i) % n;
      if (i <= n && !g.vld && req[pos[2:0]]) begin
        g.vld           = 1'b1;
        g.idx           = pos[2:0];
        g.gnt[pos[2:0]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Bit-serial restoring square root: one root bit per cycle, OUT_W cycles after start.
// done is a combinational strobe on the last step; root is that step's root.
module sqrt_iter_core
  import sqrt_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OUT_W = (WIDTH + 1) / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] radicand,
  output logic             done,
  output logic [OUT_W-1:0] root
);

  localparam int RAD_W = 2 * OUT_W;
  localparam int REM_W = OUT_W + 2;
  localparam int CNT_W = $clog2(OUT_W + 1);

  logic [RAD_W-1:0] rad_q, rad_ext;
  logic [REM_W-1:0] rem_q, rem_sh, trial, rem_nx;
  logic [OUT_W-1:0] root_q, root_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic             ge;

  always_comb begin
    // Odd widths get one zero MSB so the radicand splits into whole bit pairs.
    rad_ext                = '0;
    rad_ext[WIDTH-1:0]     = radicand;
    rem_sh                 = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
    trial                  = {root_q, 2'b01};
    ge                     = (rem_sh >= trial);
    rem_nx                 = ge ? (rem_sh - trial) : rem_sh;
    root_nx                = (root_q << 1) | OUT_W'(ge);
  end

  assign done = active_q && (cnt_q == '0);
  assign root = root_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rad_q    <= rad_ext;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= CNT_W'(OUT_W - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_nx;
      root_q <= root_nx;
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin share of one serial sqrt engine; ack pulses OUT_W+1 edges after grant.
// No queueing: requests are only sampled in IDLE and must be held until ack.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int OUT_W = (WIDTH + 1) / 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic [OUT_W-1:0]       result,
  output logic [ID_W-1:0]        result_id,
  output logic                   busy
);

  state_t            state_q, state_nx;
  logic [ID_W-1:0]   rr_ptr, id_q, win_id;
  logic [RR_MAX-1:0] req_pad;
  logic [2:0]        ptr_pad;
  rr_grant_t         g;
  logic              start, core_done;
  logic [OUT_W-1:0]  core_root;
  logic [WIDTH-1:0]  rad_sel;
  logic              unused_grant;

  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req;
    ptr_pad              = '0;
    ptr_pad[ID_W-1:0]    = rr_ptr;
  end

  assign g            = rr_next_grant(req_pad, ptr_pad, N_REQ);
  assign win_id       = g.idx[ID_W-1:0];
  assign start        = (state_q == IDLE) && g.vld;
  assign unused_grant = ^{g.gnt, g.idx};

  always_comb begin
    rad_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (g.gnt[i]) rad_sel = req_data[i*WIDTH +: WIDTH];
  end

  sqrt_iter_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .radicand (rad_sel),
    .done     (core_done),
    .root     (core_root)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (g.vld)     state_nx = ITER;
      ITER:    if (core_done) state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      ack       <= '0;
      result    <= '0;
      result_id <= '0;
      busy      <= 1'b0;
    end else begin
      ack  <= '0;
      busy <= (state_nx != IDLE);
      if (start) begin
        id_q   <= win_id;
        rr_ptr <= win_id;
      end
      if (state_q == ITER && core_done) begin
        result    <= core_root;
        result_id <= id_q;
        ack       <= N_REQ'(1) << id_q;
      end
    end
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one iterative integer square-root engine between N_REQ requesters, such as parallel geofence evaluators or edge/area units that each need floor(sqrt(x)).
- Replaces a large combinational square root with a bit-serial core that produces one result bit per cycle.
- Round-robin arbitration selects the requester; the result returns with the winner's ID and a one-cycle ack.
- Sits between the geometry datapaths and the shared arithmetic resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 23, radicand width in bits.
- OUT_W, (WIDTH+1)/2 = 12, root width in bits.
- ID_W, $clog2(N_REQ) = 2, requester index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- req_data  input  N_REQ*WIDTH  radicands; requester i occupies bits [i*WIDTH +: WIDTH].
- ack  output  N_REQ  one-hot, one-cycle pulse to the served requester.
- result  output  OUT_W  floor(sqrt(latched radicand)); valid while any ack bit is high.
- result_id  output  ID_W  index of the served requester; valid with ack.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: ack=0, result=0, result_id=0, busy=0, state=IDLE, rr_ptr=N_REQ-1, so requester 0 wins first. All outputs are registered.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - If req is all zero, stay in IDLE.
  - Otherwise grant the first set bit searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - At that edge: latch the winner's radicand and ID, set rr_ptr to the winner, clear the remainder and root, set iter_cnt=OUT_W-1, go to ITER.
- ITER:
  - Each cycle performs one restoring step of the digit-by-digit root.
  - Shift the next two radicand MSBs into the remainder.
  - Form the trial value as (root<<2)|1.
  - If remainder >= trial: remainder -= trial and root = (root<<1)|1. Otherwise root <<= 1.
  - Remainder width is OUT_W+2 bits.
  - When iter_cnt==0, register result=root, result_id, and ack[id]=1, then go to DONE. Otherwise decrement iter_cnt.
- DONE: ack and result are visible for exactly one cycle. At the next edge ack returns to 0 and the FSM goes to IDLE. result holds its last value until the next completion.
- Latency: with a grant at edge t, ack is high during the cycle after edge t+OUT_W, i.e. OUT_W+1 edges. Throughput is one result per OUT_W+2 cycles.
- Requester protocol:
  - Hold req high until its ack pulse.
  - req_data may change after the grant edge; the latched copy is used.
  - Drop req in the ack cycle unless another result is wanted.
  - If req is still high in the IDLE cycle after DONE, it competes again at lowest priority.
- req deasserted mid-computation: the computation completes and ack still pulses; no abort.
- Requests arriving while busy are not queued; they are sampled only in IDLE.
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ-1 services.
- Reset mid-operation: the FSM returns to IDLE immediately, ack drops to 0, and rr_ptr is restored. The computation is lost and no ack is issued.
- Radicand of WIDTH bits with odd WIDTH: zero-extend by one MSB to an even width before pair shifting.

Decomposition:
- Package sqrt_arb_pkg holds:
  - the state enum typedef {IDLE, ITER, DONE};
  - default width constants: WIDTH=23, OUT_W=12;
  - a round-robin next-grant function (req vector, pointer) returning a one-hot grant and an index.
- Sub-module sqrt_iter_core contains the remainder/root/counter registers, with ports start, radicand, done, and root. The arbiter FSM instantiates it once and owns arbitration and the ack/ID outputs.

Test Plan:
- Single request: req=0001, req_data[0]=25 -> ack=0001 exactly 13 cycles after grant, result=5, result_id=0, busy high throughout the computation.
- Boundary values via requester 2:
  - 0 -> 0
  - 24 -> 4
  - 1 -> 1
  - 8388607 -> 2896
  - Each completes with ack=0100.
- All four requesters held high with data 100/400/900/1600 -> acks in order 0,1,2,3 with results 10/20/30/40. Requester 0 re-asserted afterward is served after requester 3.
- rr_ptr=1 with req=1001 -> requester 3 is served before requester 0. No request is starved over 100 random cycles; scoreboard checks a maximum wait of 3 services.
- Data changed to 9 one cycle after granting 49 -> result=7. req dropped mid-ITER -> ack still pulses once.
- reset asserted during ITER -> ack=0 and busy=0 immediately. With req=0010 afterward, requester 1 is served with a correct result and no stale ack appears.
